// File: rtl/src_operand_fetch_if.sv
// rtl/src_operand_fetch_if.sv - data-memory word-read port used by the source-operand sequencer
interface src_operand_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/src_operand_fetch.sv
// rtl/src_operand_fetch.sv - MSP430 source-operand sequencer (As modes, constant generators, autoincrement)
// Optional ack timeout enabled by SRC_FETCH_TIMEOUT_EN.
module src_operand_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 as,
    input  logic [3:0]                 src_reg,
    input  logic                       bw,
    input  logic [15:0]                pc_in,
    input  logic [15:0]                reg_sout,
    output logic [3:0]                 reg_sa,
    output logic                       reg_rw,
    output logic [3:0]                 reg_da,
    output logic [15:0]                reg_din,
    output logic                       pc_inc,
    src_operand_fetch_if.master        mem,
    output logic [15:0]                operand,
    output logic [15:0]                op_addr,
    output logic                       op_valid,
    output logic                       busy,
    output logic                       fetch_err
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXT  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state;
    logic [1:0]  as_q;
    logic [3:0]  src_q;
    logic        bw_q;
    logic [15:0] ea;
    logic [15:0] data;
    logic [15:0] pc_q;
    logic        is_const;
    logic [15:0] const_val;
    logic        ack;
    logic        timeout_hit;
    logic [15:0] idx_ea;
    logic [15:0] rd_data;
    logic [15:0] ext_data;
    logic [15:0] inc;

    // The new source register is presented in the start cycle so reg_sout is usable at the start edge.
    assign reg_sa = (rst && state == S_IDLE && start) ? src_reg : src_q;
    assign busy   = (state != S_IDLE);
    assign ack    = mem.mem_req && mem.mem_ack;

    always_comb begin
        is_const  = (src_reg == 4'd3) || (src_reg == 4'd2 && as[1]);
        const_val = 16'h0000;
        case (as)
            2'b00: const_val = 16'h0000;
            2'b01: const_val = 16'h0001;
            2'b10: const_val = (src_reg == 4'd3) ? 16'h0002 : 16'h0004;
            2'b11: const_val = (src_reg == 4'd3) ? 16'hFFFF : 16'h0008;
            default: const_val = 16'h0000;
        endcase
    end

    assign idx_ea   = ((src_q == 4'd0) ? pc_q : (src_q == 4'd2) ? 16'h0000 : reg_sout) + mem.mem_rdata;
    assign rd_data  = bw_q ? {8'h00, (ea[0] ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0])} : mem.mem_rdata;
    assign ext_data = bw_q ? {8'h00, mem.mem_rdata[7:0]} : mem.mem_rdata;
    // PC and SP always step by a word, even for byte operations.
    assign inc      = (bw_q && src_q > 4'd1) ? 16'd1 : 16'd2;

`ifdef SRC_FETCH_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        timed_out;

    assign timeout_hit = mem.mem_req && !mem.mem_ack && (to_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt    <= 16'h0000;
            timed_out <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            if (!mem.mem_req || mem.mem_ack)
                to_cnt <= 16'h0000;
            else
                to_cnt <= to_cnt + 16'd1;
            if (state == S_IDLE && start) begin
                timed_out <= 1'b0;
                fetch_err <= 1'b0;
            end else if (timeout_hit) begin
                timed_out <= 1'b1;
            end
            if (state == S_DONE)
                fetch_err <= timed_out;
        end
    end
`else
    assign timeout_hit = 1'b0;
    // Always 0; TIMEOUT is only meaningful when the timeout counter is built.
    assign fetch_err   = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            as_q         <= 2'b00;
            src_q        <= 4'd0;
            bw_q         <= 1'b0;
            ea           <= 16'h0000;
            data         <= 16'h0000;
            pc_q         <= 16'h0000;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= 16'h0000;
            reg_rw       <= 1'b0;
            reg_da       <= 4'd0;
            reg_din      <= 16'h0000;
            pc_inc       <= 1'b0;
            operand      <= 16'h0000;
            op_addr      <= 16'h0000;
            op_valid     <= 1'b0;
        end else begin
            pc_inc   <= 1'b0;
            reg_rw   <= 1'b0;
            op_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    as_q  <= as;
                    src_q <= src_reg;
                    bw_q  <= bw;
                    if (is_const) begin
                        data  <= const_val;
                        ea    <= 16'h0000;
                        state <= S_DONE;
                    end else if (as == 2'b00) begin
                        data  <= bw ? {8'h00, reg_sout[7:0]} : reg_sout;
                        ea    <= 16'h0000;
                        state <= S_DONE;
                    end else if (as == 2'b01 || (as == 2'b11 && src_reg == 4'd0)) begin
                        pc_q         <= pc_in;
                        mem.mem_addr <= {pc_in[15:1], 1'b0};
                        mem.mem_req  <= 1'b1;
                        state        <= S_EXT;
                    end else begin
                        ea           <= reg_sout;
                        mem.mem_addr <= {reg_sout[15:1], 1'b0};
                        mem.mem_req  <= 1'b1;
                        state        <= S_RD;
                    end
                end
                S_EXT: if (ack) begin
                    pc_inc <= 1'b1;
                    if (as_q == 2'b01) begin
                        ea           <= idx_ea;
                        mem.mem_addr <= {idx_ea[15:1], 1'b0};
                        state        <= S_RD;
                    end else begin
                        data        <= ext_data;
                        ea          <= pc_q;
                        mem.mem_req <= 1'b0;
                        state       <= S_DONE;
                    end
                end else if (timeout_hit) begin
                    mem.mem_req <= 1'b0;
                    data        <= 16'hFFFF;
                    state       <= S_DONE;
                end
                S_RD: if (ack) begin
                    data        <= rd_data;
                    mem.mem_req <= 1'b0;
                    if (as_q == 2'b11) begin
                        reg_rw  <= 1'b1;
                        reg_da  <= src_q;
                        reg_din <= ea + inc;
                        state   <= S_WB;
                    end else begin
                        state <= S_DONE;
                    end
                end else if (timeout_hit) begin
                    mem.mem_req <= 1'b0;
                    data        <= 16'hFFFF;
                    state       <= S_DONE;
                end
                S_WB: state <= S_DONE;
                S_DONE: begin
                    op_valid <= 1'b1;
                    operand  <= data;
                    op_addr  <= ea;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_src_operand_fetch.sv
// tb/tb_src_operand_fetch.sv - randomized self-checking bench for src_operand_fetch
`timescale 1ns/1ps
module tb_src_operand_fetch;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  as = 2'b00;
    logic [3:0]  src_reg = 4'd0;
    logic        bw = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] reg_sout;
    logic [3:0]  reg_sa;
    logic        reg_rw;
    logic [3:0]  reg_da;
    logic [15:0] reg_din;
    logic        pc_inc;
    logic [15:0] operand;
    logic [15:0] op_addr;
    logic        op_valid;
    logic        busy;
    logic        fetch_err;

    src_operand_fetch_if mif();

    src_operand_fetch #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .as(as), .src_reg(src_reg), .bw(bw),
        .pc_in(pc_in), .reg_sout(reg_sout), .reg_sa(reg_sa), .reg_rw(reg_rw),
        .reg_da(reg_da), .reg_din(reg_din), .pc_inc(pc_inc), .mem(mif),
        .operand(operand), .op_addr(op_addr), .op_valid(op_valid), .busy(busy),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    logic [15:0] regs [16];
    assign reg_sout = regs[reg_sa];

    logic [15:0] mem_img [logic [15:0]];

    int checks = 0;
    int errors = 0;

    int          n_pcinc, n_rw, n_valid, n_busy, n_req, addr_bad;
    logic [3:0]  rw_da;
    logic [15:0] rw_din;
    logic [15:0] addr_log [$];
    logic [15:0] exp_addrs [$];
    int          wait_n = 0;
    bit          mem_on = 1'b1;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    int          wcnt = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return 16'(a * 16'd40503) ^ 16'h5AA5;
    endfunction

    // Reference: result of one source fetch derived directly from the addressing-mode rules.
    function automatic void model(input logic [1:0] a, input logic [3:0] s, input logic b,
                                  input logic [15:0] pc, input logic [15:0] sv,
                                  output logic [15:0] e_op, output logic [15:0] e_addr,
                                  output logic [15:0] e_din, output int e_pcinc, output int e_rw);
        logic [15:0] ext, ea, w;
        bit rd;
        exp_addrs.delete();
        e_op = 16'h0; e_addr = 16'h0; e_din = 16'h0; e_pcinc = 0; e_rw = 0; rd = 0; ea = 16'h0;
        if (s == 4'd3) begin
            e_op = (a == 2'd3) ? 16'hFFFF : 16'(a);
        end else if (s == 4'd2 && a >= 2'd2) begin
            e_op = (a == 2'd2) ? 16'd4 : 16'd8;
        end else begin
            case (a)
                2'd0: e_op = b ? (sv & 16'h00FF) : sv;
                2'd1: begin
                    ext = mem_word(pc);
                    exp_addrs.push_back(pc);
                    e_pcinc = 1;
                    ea = ((s == 4'd0) ? pc : (s == 4'd2) ? 16'h0000 : sv) + ext;
                    rd = 1;
                end
                2'd2: begin ea = sv; rd = 1; end
                default: begin
                    if (s == 4'd0) begin
                        ext = mem_word(pc);
                        exp_addrs.push_back(pc);
                        e_pcinc = 1;
                        e_op = b ? (ext & 16'h00FF) : ext;
                        e_addr = pc;
                    end else begin
                        ea = sv; rd = 1; e_rw = 1;
                        e_din = sv + ((b && s > 4'd1) ? 16'd1 : 16'd2);
                    end
                end
            endcase
        end
        if (rd) begin
            w = mem_word(ea & 16'hFFFE);
            exp_addrs.push_back(ea & 16'hFFFE);
            e_addr = ea;
            e_op = b ? (ea[0] ? (w >> 8) : (w & 16'h00FF)) : w;
        end
    endfunction

    task automatic clear_logs;
        n_pcinc = 0; n_rw = 0; n_valid = 0; n_busy = 0; n_req = 0; addr_bad = 0;
        rw_da = 4'd0; rw_din = 16'h0; addr_log.delete();
    endtask

    // Observer plus memory responder; ack after wait_n wait cycles, random acks while idle.
    initial begin
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (pc_inc) n_pcinc++;
            if (reg_rw) begin n_rw++; rw_da = reg_da; rw_din = reg_din; end
            if (op_valid) n_valid++;
            if (busy) n_busy++;
            if (mif.mem_req) begin
                n_req++;
                if (mif.mem_addr[0]) addr_bad++;
                if (prev_req && !prev_ack && mif.mem_addr != prev_addr) addr_bad++;
            end
            prev_req = mif.mem_req;
            prev_addr = mif.mem_addr;
            if (mif.mem_req && mem_on) begin
                if (wcnt >= wait_n) begin
                    mif.mem_ack = 1'b1;
                    mif.mem_rdata = mem_word(mif.mem_addr);
                    addr_log.push_back(mif.mem_addr);
                    wcnt = 0;
                end else begin
                    mif.mem_ack = 1'b0;
                    mif.mem_rdata = 16'($urandom);
                    wcnt++;
                end
            end else begin
                mif.mem_ack = mem_on && ($urandom_range(3) == 0);
                mif.mem_rdata = 16'($urandom);
                wcnt = 0;
            end
            prev_ack = mif.mem_ack;
        end
    end

    task automatic run_op(input logic [1:0] a, input logic [3:0] s, input logic b,
                          input logic [15:0] pc, input logic [15:0] sv, input int wn,
                          input bit extra, input string tag);
        logic [15:0] e_op, e_addr, e_din, c_op, c_addr;
        logic        c_err;
        int          e_pcinc, e_rw, lat;
        bit          got, ok;
        regs[s] = sv;
        pc_in = pc;
        wait_n = wn;
        model(a, s, b, pc, sv, e_op, e_addr, e_din, e_pcinc, e_rw);
        @(negedge clk); #1;
        clear_logs();
        as = a; src_reg = s; bw = b; start = 1'b1;
        got = 0; lat = 0; c_op = 16'h0; c_addr = 16'h0; c_err = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (op_valid) begin
                got = 1; lat = k; c_op = operand; c_addr = op_addr; c_err = fetch_err;
                start = 1'b0;
                break;
            end
            if (extra) begin
                start = 1'b1; as = 2'b11; src_reg = 4'd3;
            end else begin
                start = 1'b0; as = 2'($urandom); src_reg = 4'($urandom); bw = 1'($urandom);
            end
        end
        #1;
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s op_valid: not seen within 300 cycles, required a pulse", tag);
        end
        checks++;
        if (c_op !== e_op) begin
            errors++; $display("FAIL %s operand: got %h expected %h", tag, c_op, e_op);
        end
        checks++;
        if (c_addr !== e_addr) begin
            errors++; $display("FAIL %s op_addr: got %h expected %h", tag, c_addr, e_addr);
        end
        checks++;
        if (c_err !== 1'b0) begin
            errors++; $display("FAIL %s fetch_err: got %b expected 0", tag, c_err);
        end
        checks++;
        if (n_pcinc !== e_pcinc) begin
            errors++; $display("FAIL %s pc_inc pulses: got %0d expected %0d", tag, n_pcinc, e_pcinc);
        end
        checks++;
        if (n_rw !== e_rw || (e_rw == 1 && (rw_da !== s || rw_din !== e_din))) begin
            errors++;
            $display("FAIL %s writeback: got n=%0d da=%0d din=%h expected n=%0d da=%0d din=%h",
                     tag, n_rw, rw_da, rw_din, e_rw, s, e_din);
        end
        ok = (addr_log.size() == exp_addrs.size());
        if (ok) foreach (addr_log[i]) if (addr_log[i] !== exp_addrs[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s read addresses: got %0d reads (first %h) expected %0d reads (first %h)",
                     tag, addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 16'h0,
                     exp_addrs.size(), (exp_addrs.size() > 0) ? exp_addrs[0] : 16'h0);
        end
        checks++;
        if (addr_bad != 0) begin
            errors++; $display("FAIL %s mem_addr stability: got %0d violations expected 0", tag, addr_bad);
        end
        if (exp_addrs.size() == 0) begin
            checks++;
            if (lat != 2 || n_busy != 1 || n_req != 0) begin
                errors++;
                $display("FAIL %s no-memory path: got latency %0d busy %0d req %0d expected 2 1 0",
                         tag, lat, n_busy, n_req);
            end
        end
        if (extra) begin
            repeat (4) @(negedge clk);
            #1;
            checks++;
            if (n_valid != 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s start while busy: got %0d op_valid pulses busy=%b expected 1 and 0",
                         tag, n_valid, busy);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mif.mem_req, busy, op_valid, pc_inc, reg_rw, fetch_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset strobes: got %b expected 000000",
                     {mif.mem_req, busy, op_valid, pc_inc, reg_rw, fetch_err});
        end
        checks++;
        if (operand !== 16'h0 || op_addr !== 16'h0) begin
            errors++; $display("FAIL reset operand/op_addr: got %h/%h expected 0000/0000", operand, op_addr);
        end
        checks++;
        if (mif.mem_addr !== 16'h0 || reg_din !== 16'h0 || reg_da !== 4'd0 || reg_sa !== 4'd0) begin
            errors++;
            $display("FAIL reset addresses: got mem_addr %h reg_din %h reg_da %0d reg_sa %0d expected zeros",
                     mif.mem_addr, reg_din, reg_da, reg_sa);
        end
        rst = 1'b1;
    endtask

    task automatic test_const;
        run_op(2'b11, 4'd3, 1'b0, 16'hC000, 16'h1111, 0, 0, "const_r3_11");
        run_op(2'b00, 4'd3, 1'b0, 16'hC000, 16'h2222, 0, 0, "const_r3_00");
        run_op(2'b01, 4'd3, 1'b0, 16'hC000, 16'h3333, 0, 0, "const_r3_01");
        run_op(2'b10, 4'd3, 1'b0, 16'hC000, 16'h4444, 0, 0, "const_r3_10");
        run_op(2'b10, 4'd2, 1'b0, 16'hC000, 16'h5555, 0, 0, "const_r2_10");
        run_op(2'b11, 4'd2, 1'b0, 16'hC000, 16'h6666, 0, 0, "const_r2_11");
    endtask

    task automatic test_indexed;
        mem_img[16'hC010] = 16'h0010;
        mem_img[16'h0210] = 16'hBEEF;
        run_op(2'b01, 4'd5, 1'b0, 16'hC010, 16'h0200, 0, 0, "indexed");
    endtask

    task automatic test_autoinc_byte;
        mem_img[16'h0300] = 16'h12AB;
        run_op(2'b11, 4'd6, 1'b1, 16'hC000, 16'h0301, 3, 0, "autoinc_byte");
        checks++;
        if (n_req != 4) begin
            errors++; $display("FAIL autoinc_byte request cycles: got %0d expected 4", n_req);
        end
        run_op(2'b11, 4'd1, 1'b1, 16'hC000, 16'h03FE, 1, 0, "autoinc_sp");
    endtask

    task automatic test_immediate;
        mem_img[16'hC020] = 16'h1234;
        run_op(2'b11, 4'd0, 1'b0, 16'hC020, 16'h0000, 0, 0, "immediate");
    endtask

    task automatic test_start_while_busy;
        run_op(2'b11, 4'd5, 1'b0, 16'hC100, 16'h0500, 4, 1, "busy_start");
    endtask

    task automatic test_random;
        logic [1:0] a;
        logic [3:0] s;
        logic       b;
        for (int n = 0; n < 40; n++) begin
            foreach (regs[i]) regs[i] = 16'($urandom);
            a = 2'($urandom);
            s = 4'($urandom);
            b = 1'($urandom);
            if (s == 4'd3 || (s == 4'd2 && a[1])) b = 1'b0;
            run_op(a, s, b, 16'($urandom) & 16'hFFFE, 16'($urandom), $urandom_range(0, 3), 0, "random");
        end
    endtask

    task automatic test_reset_mid;
        regs[4] = 16'h0440;
        wait_n = 1000;
        @(negedge clk); #1;
        clear_logs();
        as = 2'b10; src_reg = 4'd4; bw = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mif.mem_req !== 1'b1) begin
            errors++; $display("FAIL reset_mid request: got mem_req %b expected 1", mif.mem_req);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mif.mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid abort: got mem_req %b busy %b expected 0 0", mif.mem_req, busy);
        end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (n_valid != 0) begin
            errors++; $display("FAIL reset_mid op_valid: got %0d pulses expected 0", n_valid);
        end
        wait_n = 0;
    endtask

`ifdef SRC_FETCH_TIMEOUT_EN
    task automatic test_timeout;
        bit got;
        regs[7] = 16'h0700;
        mem_on = 1'b0;
        @(negedge clk); #1;
        clear_logs();
        as = 2'b11; src_reg = 4'd7; bw = 1'b0; start = 1'b1;
        got = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (op_valid) begin
                got = 1;
                checks++;
                if (operand !== 16'hFFFF || fetch_err !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout result: got operand %h fetch_err %b expected FFFF 1", operand, fetch_err);
                end
                break;
            end
        end
        #1;
        checks++;
        if (!got || n_req != TIMEOUT || n_pcinc != 0 || n_rw != 0) begin
            errors++;
            $display("FAIL timeout sequence: got seen=%0d req=%0d pc_inc=%0d rw=%0d expected 1 %0d 0 0",
                     got, n_req, n_pcinc, n_rw, TIMEOUT);
        end
        mem_on = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++; $display("FAIL timeout sticky: got fetch_err %b expected 1", fetch_err);
        end
        run_op(2'b11, 4'd3, 1'b0, 16'hC000, 16'h0000, 0, 0, "after_timeout");
    endtask
`else
    task automatic test_long_wait;
        mem_img[16'h0880] = 16'hA55A;
        run_op(2'b10, 4'd8, 1'b0, 16'hC000, 16'h0880, 30, 0, "long_wait");
    endtask
`endif

    initial begin
        foreach (regs[i]) regs[i] = 16'h0000;
        test_reset();
        test_const();
        test_indexed();
        test_autoinc_byte();
        test_immediate();
        test_start_while_busy();
        test_random();
        test_reset_mid();
`ifdef SRC_FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/src_operand_fetch.md
Name: src_operand_fetch

Overview:
- Source-operand sequencer for the MSP430 datapath. It drives the register file's source-address and write-back ports, and resolves all four As addressing modes: register, indexed/symbolic/absolute, indirect, and indirect-autoincrement/immediate.
- It also handles the R2/R3 constant generators and issues word reads on the shared data-memory port.
- The control unit pulses start and waits for op_valid before the execute stage.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ack (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin fetch; sampled only in IDLE.
- as  in  2  source addressing mode.
- src_reg  in  4  source register number.
- bw  in  1  1 = byte operation, 0 = word operation.
- pc_in  in  16  current PC (address of next extension word).
- reg_sout  in  16  register-file read data for reg_sa.
- reg_sa  out  4  register-file source address.
- reg_rw  out  1  register-file write strobe (autoincrement write-back).
- reg_da  out  4  register-file write address.
- reg_din  out  16  register-file write data.
- pc_inc  out  1  one-cycle pulse: extension word consumed, PC += 2.
- mem_req  out  1  memory read request.
- mem_addr  out  16  memory word address; bit 0 always 0.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  16  memory read data.
- operand  out  16  fetched source operand.
- op_addr  out  16  effective address; 0 for register and constant modes.
- op_valid  out  1  one-cycle pulse: operand/op_addr valid.
- busy  out  1  high in any state except IDLE.
- fetch_err  out  1  ack-timeout flag (optional feature).

Behaviour:
- Reset (rst=0 at posedge): state = IDLE. All outputs 0, including operand, op_addr and fetch_err. Reset wins over every other event; mem_req drops in the cycle after reset is sampled.
- reg_sa = src_reg latched at start; held stable until the next start.
- States:
  - IDLE
  - EXT: fetch extension word at pc_in.
  - RD: operand read at the effective address.
  - WB: autoincrement write-back.
  - DONE: op_valid=1 for exactly one cycle, then return to IDLE.
- From IDLE on start, the latched as/src_reg select the path:
  - Constant generator (no memory access, IDLE→DONE, op_valid 2 cycles after start):
    - src=3: 0000, 0001, 0002, FFFF for as=00/01/10/11.
    - src=2: as=10 → 0004; as=11 → 0008.
  - Register mode (as=00, src≠3): operand = reg_sout; IDLE→DONE.
  - Indexed mode (as=01, src≠3): IDLE→EXT. Read mem at pc_in, pulse pc_inc on ack. EA is:
    - src=0 (symbolic): pc_in sampled at EXT entry + ext.
    - src=2 (absolute): ext.
    - otherwise: reg_sout + ext.
    - Adds are 16-bit modulo 2^16.
    - Then EXT→RD.
  - Indirect mode (as=10, src∉{2,3}): EA = reg_sout; IDLE→RD.
  - Autoincrement mode (as=11, src∉{2,3}):
    - src=0 (immediate): IDLE→EXT. operand = ext, pulse pc_inc, op_addr = pc_in; EXT→DONE.
    - otherwise: EA = reg_sout; IDLE→RD→WB.
    - In WB, a one-cycle reg_rw pulse writes reg_da = src_reg and reg_din = EA + inc, modulo 2^16.
    - inc = 1 if bw=1 and src∉{0,1}; else inc = 2 (SP always steps by 2).
    - WB→DONE.
- Memory handshake:
  - mem_req rises on entering EXT/RD.
  - mem_addr = {addr[15:1],0} is held constant while mem_req=1.
  - mem_req deasserts in the cycle after mem_ack is sampled high.
  - An ack already high in the first request cycle is accepted (0-wait memory).
  - mem_ack while mem_req=0 is ignored.
- Byte data in RD: operand = {8'h00, EA[0] ? mem_rdata[15:8] : mem_rdata[7:0]}.
- Byte register mode: operand = {8'h00, reg_sout[7:0]}.
- Byte immediate mode: operand = {8'h00, ext[7:0]}.
- Word data: operand = mem_rdata.
- operand and op_addr hold their value after op_valid until the next op_valid.
- start while busy is ignored and not queued. start in the DONE cycle is ignored.

Optional Feature:
- Macro SRC_FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs while mem_req=1.
  - If TIMEOUT cycles elapse with no ack: mem_req drops, state → DONE, and operand = FFFF.
  - fetch_err is set with op_valid and stays set until the next start or reset.
  - No pc_inc and no write-back occur on timeout.
- Undefined: no counter; waits for ack indefinitely; fetch_err tied 0.

Test Plan:
1. as=11, src=3, start → op_valid 2 cycles later with operand=FFFF, mem_req never asserted, busy high 1 cycle.
2. as=01, src=5, reg_sout=0x0200, pc_in=0xC010, ext=0x0010, mem[0x0210]=0xBEEF, 0-wait ack → one pc_inc pulse, mem_addr 0xC010 then 0x0210, operand=BEEF, op_addr=0210.
3. as=11, src=6, bw=1, reg_sout=0x0301, mem[0x0300]=0x12AB, ack after 3 wait cycles → mem_addr=0300 held 4 cycles, operand=0x0012, reg_rw pulse with reg_da=6 and reg_din=0302.
4. as=11, src=1, bw=1, reg_sout=0x03FE → write-back reg_din=0400 (SP step of 2 despite byte op).
5. as=11, src=0, pc_in=0xC020, mem[0xC020]=0x1234 → operand=1234, pc_inc pulse, no reg_rw.
6. rst=0 asserted while mem_req=1 in RD → next cycle mem_req=0, busy=0, op_valid never pulses. With SRC_FETCH_TIMEOUT_EN and TIMEOUT=16, no ack → op_valid after 16 wait cycles with fetch_err=1 and operand=FFFF.
